// File: rtl/ocp_mem_bist_if.sv
// OCP master/slave signal bundle used by the memory BIST initiator.
// The OCP width and encoding macros are defined here as well as in the core.
`ifndef OCP_MEM_BIST_DEFS
`define OCP_MEM_BIST_DEFS
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`define BEN_WIDTH 4
`define OCP_CMD_IDLE 3'b000
`define OCP_CMD_WRITE 3'b001
`define OCP_CMD_READ 3'b010
`define OCP_RESP_NULL 2'b00
`define OCP_RESP_DVA 2'b01
`define OCP_RESP_ERR 2'b11
`endif

interface ocp_mem_bist_if;
  logic [`ADDR_WIDTH-1:0] o_MAddr;
  logic [2:0]             o_MCmd;
  logic [`DATA_WIDTH-1:0] o_MData;
  logic [`BEN_WIDTH-1:0]  o_MByteEn;
  logic                   i_SCmdAccept;
  logic [`DATA_WIDTH-1:0] i_SData;
  logic [1:0]             i_SResp;

  modport master (
    output o_MAddr, o_MCmd, o_MData, o_MByteEn,
    input  i_SCmdAccept, i_SData, i_SResp
  );

  modport slave (
    input  o_MAddr, o_MCmd, o_MData, o_MByteEn,
    output i_SCmdAccept, i_SData, i_SResp
  );
endinterface

// File: rtl/ocp_mem_bist.sv
// OCP RAM BIST initiator: write pattern pass, read-compare pass.
// Define OCP_BIST_LFSR_EN for an LFSR pattern; default is address XOR seed.
`ifndef OCP_MEM_BIST_DEFS
`define OCP_MEM_BIST_DEFS
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`define BEN_WIDTH 4
`define OCP_CMD_IDLE 3'b000
`define OCP_CMD_WRITE 3'b001
`define OCP_CMD_READ 3'b010
`define OCP_RESP_NULL 2'b00
`define OCP_RESP_DVA 2'b01
`define OCP_RESP_ERR 2'b11
`endif

module ocp_mem_bist #(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_start,
  input  logic [`ADDR_WIDTH-1:0] i_base,
  input  logic [15:0]            i_count,
  input  logic [`DATA_WIDTH-1:0] i_seed,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_fail,
  output logic                   o_timeout,
  output logic [15:0]            o_err_count,
  output logic [`ADDR_WIDTH-1:0] o_fail_addr,
  ocp_mem_bist_if.master         bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_CMD, S_WR_RESP,
    S_RD_CMD, S_RD_RESP, S_DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(RESP_TIMEOUT - 1);
  localparam logic [`ADDR_WIDTH-1:0] A_MASK = ~(`ADDR_WIDTH'(3));

  state_t                 r_state, w_nstate;
  logic [`ADDR_WIDTH-1:0] r_ptr, w_ptr_nx;
  logic [`ADDR_WIDTH-1:0] r_base, w_base_nx;
  logic [15:0]            r_cnt, w_cnt_nx;
  logic [15:0]            r_cnt0, w_cnt0_nx;
  logic [`DATA_WIDTH-1:0] r_seed, w_seed_nx;
  logic [7:0]             r_tmo, w_tmo_nx;
  logic                   w_clr, w_err, w_tmo_hit, w_adv;
  logic                   w_resp;
  logic [`DATA_WIDTH-1:0] w_pat, w_pat_nx;

  logic                   r_busy, r_done, r_fail, r_timeout;
  logic [15:0]            r_err_count;
  logic [`ADDR_WIDTH-1:0] r_fail_addr, r_maddr;
  logic [2:0]             r_mcmd;
  logic [`DATA_WIDTH-1:0] r_mdata;
  logic [`BEN_WIDTH-1:0]  r_mben;

`ifdef OCP_BIST_LFSR_EN
  logic [`DATA_WIDTH-1:0] r_lfsr, w_lfsr_nx, w_seed_in;

  // Galois form, polynomial 0x80200003; a zero seed would lock up
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  assign w_seed_in = (i_seed == '0) ? `DATA_WIDTH'(1) : i_seed;
  assign w_pat     = r_lfsr;
  assign w_pat_nx  = w_lfsr_nx;
`else
  logic [`DATA_WIDTH-1:0] w_seed_in;

  assign w_seed_in = i_seed;
  assign w_pat     = r_ptr ^ r_seed;
  assign w_pat_nx  = w_ptr_nx ^ w_seed_nx;
`endif

  assign w_resp = bus.i_SResp != `OCP_RESP_NULL;

  always_comb begin
    w_nstate  = r_state;
    w_ptr_nx  = r_ptr;
    w_base_nx = r_base;
    w_cnt_nx  = r_cnt;
    w_cnt0_nx = r_cnt0;
    w_seed_nx = r_seed;
    w_tmo_nx  = r_tmo;
    w_clr     = 1'b0;
    w_err     = 1'b0;
    w_tmo_hit = 1'b0;
    w_adv     = 1'b0;
`ifdef OCP_BIST_LFSR_EN
    w_lfsr_nx = r_lfsr;
`endif
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_clr     = 1'b1;
          w_base_nx = i_base & A_MASK;
          w_ptr_nx  = i_base & A_MASK;
          w_cnt_nx  = i_count;
          w_cnt0_nx = i_count;
          w_seed_nx = w_seed_in;
`ifdef OCP_BIST_LFSR_EN
          w_lfsr_nx = w_seed_in;
`endif
          w_nstate  = (i_count == 16'd0) ? S_DONE : S_WR_CMD;
        end
      end
      S_WR_CMD: begin
        if (bus.i_SCmdAccept) begin
          w_nstate = S_WR_RESP;
          w_tmo_nx = 8'd0;
        end
      end
      S_RD_CMD: begin
        if (bus.i_SCmdAccept) begin
          w_nstate = S_RD_RESP;
          w_tmo_nx = 8'd0;
        end
      end
      S_WR_RESP, S_RD_RESP: begin
        if (w_resp) begin
          w_adv = 1'b1;
          w_err = (bus.i_SResp == `OCP_RESP_ERR) ||
                  ((r_state == S_RD_RESP) &&
                   (bus.i_SData != w_pat));
        end else if (r_tmo == TMO_LAST) begin
          w_tmo_hit = 1'b1;
          w_nstate  = S_DONE;
        end else begin
          w_tmo_nx = r_tmo + 8'd1;
        end
      end
      default: w_nstate = S_IDLE;
    endcase

    if (w_adv) begin
      if (r_cnt == 16'd1) begin
        w_ptr_nx = r_base;
        w_cnt_nx = r_cnt0;
`ifdef OCP_BIST_LFSR_EN
        w_lfsr_nx = r_seed;
`endif
        w_nstate = (r_state == S_WR_RESP) ? S_RD_CMD : S_DONE;
      end else begin
        w_ptr_nx = r_ptr + `ADDR_WIDTH'(4);
        w_cnt_nx = r_cnt - 16'd1;
`ifdef OCP_BIST_LFSR_EN
        w_lfsr_nx = lfsr_step(r_lfsr);
`endif
        w_nstate = (r_state == S_WR_RESP) ? S_WR_CMD : S_RD_CMD;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_base  <= '0;
      r_cnt   <= '0;
      r_cnt0  <= '0;
      r_seed  <= '0;
      r_tmo   <= '0;
`ifdef OCP_BIST_LFSR_EN
      r_lfsr  <= '0;
`endif
    end else begin
      r_state <= w_nstate;
      r_ptr   <= w_ptr_nx;
      r_base  <= w_base_nx;
      r_cnt   <= w_cnt_nx;
      r_cnt0  <= w_cnt0_nx;
      r_seed  <= w_seed_nx;
      r_tmo   <= w_tmo_nx;
`ifdef OCP_BIST_LFSR_EN
      r_lfsr  <= w_lfsr_nx;
`endif
    end
  end

  // Bus outputs are registered from the next-state view
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mcmd  <= `OCP_CMD_IDLE;
      r_maddr <= '0;
      r_mdata <= '0;
      r_mben  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_maddr <= w_ptr_nx;
      r_mdata <= w_pat_nx;
      r_busy  <= (w_nstate != S_IDLE) &&
                 (w_nstate != S_DONE);
      r_done  <= w_nstate == S_DONE;
      unique case (1'b1)
        w_nstate == S_WR_CMD: begin
          r_mcmd <= `OCP_CMD_WRITE;
          r_mben <= '1;
        end
        w_nstate == S_RD_CMD: begin
          r_mcmd <= `OCP_CMD_READ;
          r_mben <= '1;
        end
        default: begin
          r_mcmd <= `OCP_CMD_IDLE;
          r_mben <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_count <= '0;
      r_fail_addr <= '0;
    end else if (w_clr) begin
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_count <= '0;
      r_fail_addr <= '0;
    end else begin
      if (w_err && (r_err_count != 16'hFFFF))
        r_err_count <= r_err_count + 16'd1;
      if (w_tmo_hit)
        r_timeout <= 1'b1;
      if (w_err || w_tmo_hit) begin
        r_fail <= 1'b1;
        if (!r_fail)
          r_fail_addr <= r_ptr;
      end
    end
  end

  assign bus.o_MCmd    = r_mcmd;
  assign bus.o_MAddr   = r_maddr;
  assign bus.o_MData   = r_mdata;
  assign bus.o_MByteEn = r_mben;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_fail        = r_fail;
  assign o_timeout     = r_timeout;
  assign o_err_count   = r_err_count;
  assign o_fail_addr   = r_fail_addr;

endmodule

// File: tb/tb_ocp_mem_bist.sv
// Directed bench for ocp_mem_bist against a small OCP RAM model
// with accept-wait, read-corruption and dropped-response knobs.
module tb_ocp_mem_bist;

  localparam logic [2:0] C_IDLE = 3'd0;
  localparam logic [2:0] C_WR   = 3'd1;
  localparam logic [2:0] C_RD   = 3'd2;
  localparam logic [1:0] R_NULL = 2'd0;
  localparam logic [1:0] R_DVA  = 2'd1;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_base = '0;
  logic [15:0] i_count = '0;
  logic [31:0] i_seed = '0;
  logic        o_busy, o_done, o_fail, o_timeout;
  logic [15:0] o_err_count;
  logic [31:0] o_fail_addr;

  ocp_mem_bist_if bus();

  ocp_mem_bist #(.RESP_TIMEOUT(10)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_start     (i_start),
    .i_base      (i_base),
    .i_count     (i_count),
    .i_seed      (i_seed),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_fail      (o_fail),
    .o_timeout   (o_timeout),
    .o_err_count (o_err_count),
    .o_fail_addr (o_fail_addr),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model knobs
  int          acc_wait = 0;
  int          drop_idx = -1;
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h8;

  logic [31:0] mem [16];
  int          r_wait;
  int          r_wrn;
  logic [1:0]  r_sresp;
  logic [31:0] r_sdata;

  always_comb
    bus.i_SCmdAccept = (bus.o_MCmd != C_IDLE) &&
                       (r_wait == acc_wait);
  assign bus.i_SResp = r_sresp;
  assign bus.i_SData = r_sdata;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wait  <= 0;
      r_wrn   <= 0;
      r_sresp <= R_NULL;
      r_sdata <= '0;
    end else begin
      r_sresp <= R_NULL;
      if (i_start) r_wrn <= 0;
      if (bus.o_MCmd != C_IDLE && !bus.i_SCmdAccept)
        r_wait <= r_wait + 1;
      else
        r_wait <= 0;
      if (bus.o_MCmd != C_IDLE && bus.i_SCmdAccept) begin
        if (bus.o_MCmd == C_WR) begin
          mem[bus.o_MAddr[5:2]] <= bus.o_MData;
          r_wrn <= r_wrn + 1;
          if (r_wrn != drop_idx) r_sresp <= R_DVA;
        end else begin
          r_sresp <= R_DVA;
          r_sdata <= mem[bus.o_MAddr[5:2]] ^
            ((corrupt_en && bus.o_MAddr == corrupt_addr)
              ? 32'h1 : 32'h0);
        end
      end
    end
  end

  // bus monitor: accepted commands and stability while stalled
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          acc_cyc[$];
  int          viol = 0;
  logic        pend = 1'b0;
  logic [2:0]  pc;
  logic [31:0] pa, pd;

  always @(negedge clk) begin
    if (!nrst) begin
      pend = 1'b0;
    end else if (bus.o_MCmd != C_IDLE) begin
      if (bus.o_MByteEn != 4'hF) viol++;
      if (pend && (bus.o_MCmd != pc ||
          bus.o_MAddr != pa || bus.o_MData != pd))
        viol++;
      if (bus.i_SCmdAccept) begin
        pend = 1'b0;
        acc_cyc.push_back(cyc);
        if (bus.o_MCmd == C_WR) begin
          wr_addr.push_back(bus.o_MAddr);
          wr_data.push_back(bus.o_MData);
        end
      end else begin
        pend = 1'b1;
        pc = bus.o_MCmd;
        pa = bus.o_MAddr;
        pd = bus.o_MData;
      end
    end else begin
      if (pend) viol++;
      pend = 1'b0;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [31:0] b,
                       input logic [15:0] c,
                       input logic [31:0] s);
    @(negedge clk);
    i_base = b;
    i_count = c;
    i_seed = s;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int t);
    int n;
    n = 0;
    while (!o_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    if (!o_done) check("done_bound", 32'(o_done), 32'd1);
  endtask

  int b, ba, v0, t, n;

  initial begin
    #1;
    check("rst_mcmd", 32'(bus.o_MCmd), 32'(C_IDLE));
    check("rst_ben", 32'(bus.o_MByteEn), 32'd0);
    check("rst_flags",
          {28'd0, o_busy, o_done, o_fail, o_timeout}, 32'd0);
    check("rst_addr", bus.o_MAddr, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // zero-wait pass: 4 words, 16 cycles first command to done
    b = acc_cyc.size();
    ba = wr_addr.size();
    start(32'h0, 16'd4, 32'hA5A5_A5A5);
    wait_done(t);
    check("t1_cycles", 32'(t - acc_cyc[b]), 32'd16);
    check("t1_fail", 32'(o_fail), 32'd0);
    check("t1_err", 32'(o_err_count), 32'd0);
    check("t1_busy", 32'(o_busy), 32'd0);
    check("t1_ncmd", 32'(acc_cyc.size() - b), 32'd8);
    check("t1_addr3", wr_addr[ba + 3], 32'hC);
    check("t1_data1", wr_data[ba + 1], 32'hA5A5_A5A1);

    // read at 0x8 corrupted
    corrupt_en = 1'b1;
    corrupt_addr = 32'h8;
    start(32'h0, 16'd4, 32'hA5A5_A5A5);
    wait_done(t);
    corrupt_en = 1'b0;
    check("t2_fail", 32'(o_fail), 32'd1);
    check("t2_err", 32'(o_err_count), 32'd1);
    check("t2_faddr", o_fail_addr, 32'h8);
    check("t2_tmo", 32'(o_timeout), 32'd0);

    // 3-cycle accept stall on every command
    acc_wait = 3;
    v0 = viol;
    start(32'h10, 16'd4, 32'h0F0F_3C3C);
    wait_done(t);
    acc_wait = 0;
    check("t3_stable", 32'(viol - v0), 32'd0);
    check("t3_fail", 32'(o_fail), 32'd0);
    check("t3_err", 32'(o_err_count), 32'd0);

    // third write never answered
    drop_idx = 2;
    b = acc_cyc.size();
    start(32'h0, 16'd4, 32'h1111_2222);
    wait_done(t);
    drop_idx = -1;
    check("t4_tmo", 32'(o_timeout), 32'd1);
    check("t4_fail", 32'(o_fail), 32'd1);
    check("t4_faddr", o_fail_addr, 32'h8);
    check("t4_err", 32'(o_err_count), 32'd0);
    // edges from the accepting edge to the DONE edge
    check("t4_cycles", 32'(t - (acc_cyc[b + 2] + 1)), 32'd10);

    // zero count: done one cycle after start, nothing issued
    b = acc_cyc.size();
    @(negedge clk);
    i_base = 32'h20;
    i_count = 16'd0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("t5_done", 32'(o_done), 32'd1);
    check("t5_clr", {30'd0, o_fail, o_timeout}, 32'd0);
    check("t5_busy", 32'(o_busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t5_ncmd", 32'(acc_cyc.size() - b), 32'd0);

    // address wrap, low base bits ignored
    ba = wr_addr.size();
    start(32'hFFFF_FFFB, 16'd4, 32'h1234_5678);
    wait_done(t);
    check("t6_addr0", wr_addr[ba], 32'hFFFF_FFF8);
    check("t6_addr2", wr_addr[ba + 2], 32'h0);
    check("t6_addr3", wr_addr[ba + 3], 32'h4);
    check("t6_data2", wr_data[ba + 2], 32'h1234_5678);
    check("t6_fail", 32'(o_fail), 32'd0);

    // reset mid read pass, after a failure has been recorded
    corrupt_en = 1'b1;
    corrupt_addr = 32'h0;
    start(32'h0, 16'd4, 32'h5555_0000);
    n = 0;
    while (!(bus.o_MCmd == C_RD && bus.o_MAddr == 32'h4)
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t7_reach", 32'(bus.o_MCmd), 32'(C_RD));
    check("t7_prefail", 32'(o_fail), 32'd1);
    nrst = 1'b0;
    #1;
    check("t7_mcmd", 32'(bus.o_MCmd), 32'(C_IDLE));
    check("t7_ben", 32'(bus.o_MByteEn), 32'd0);
    check("t7_addr", bus.o_MAddr, 32'd0);
    check("t7_data", bus.o_MData, 32'd0);
    check("t7_flags",
          {28'd0, o_busy, o_done, o_fail, o_timeout}, 32'd0);
    check("t7_err", 32'(o_err_count), 32'd0);
    check("t7_faddr", o_fail_addr, 32'd0);
    corrupt_en = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    start(32'h40, 16'd2, 32'hDEAD_BEEF);
    wait_done(t);
    check("t8_done", 32'(o_done), 32'd1);
    check("t8_fail", 32'(o_fail), 32'd0);
    check("t8_err", 32'(o_err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
